// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command sequencer: op codes,
// sequencer states and the nominal control-unit latency.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } calc_op_e;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'b00,
        ST_IDLE  = 2'b01,
        ST_ISSUE = 2'b10,
        ST_WAIT  = 2'b11
    } seq_state_e;

    // Cycles from a go pulse to the CU raising done.
    localparam int CU_LATENCY = 5;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Small command FIFO: DEPTH entries of {op, a, b}. Read data is shown
// combinationally at the head. A push is dropped when full and a pop is
// dropped when empty, so the caller may offer both freely.
module calc_cmd_fifo #(
    parameter int DW    = 18,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally mod DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Host-side initiator for the 4-op calculator control unit. Queues commands,
// issues each one as a single-cycle go with operands held, waits for done
// (or a timeout) and hands the result out through a one-entry result slot.
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int W         = 8,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 16,
    parameter int FLUSH_CYC = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic         go,
    output logic [1:0]   op,
    output logic [W-1:0] in1,
    output logic [W-1:0] in2,
    input  logic         calc_done,
    input  logic [W-1:0] calc_res,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [1:0]   res_op,
    output logic         res_err,
    output logic         busy
);
    localparam int DW = 2 + 2 * W;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

    seq_state_e    state_q;
    logic [FW-1:0] flush_q;
    logic [TW-1:0] timer_q;
    logic          go_q;
    calc_op_e      op_q;
    logic [W-1:0]  in1_q;
    logic [W-1:0]  in2_q;
    logic          res_valid_q;
    logic [W-1:0]  res_data_q;
    calc_op_e      res_op_q;
    logic          res_err_q;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_wdata;
    logic [DW-1:0] fifo_rdata;
    logic          res_pop;
    logic          issue_ok;

    // The slot may be refilled by the command issued in the same cycle the
    // consumer drains it, since the capture lands many cycles later.
    assign res_pop    = res_valid_q && res_ready;
    assign issue_ok   = (state_q == ST_IDLE) && !fifo_empty && (!res_valid_q || res_ready);
    assign cmd_ready  = !fifo_full && (state_q != ST_FLUSH);
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_pop   = issue_ok;
    assign fifo_wdata = {cmd_op, cmd_a, cmd_b};

    calc_cmd_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Sequencer FSM with flush counter, WAIT timer and the result slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FLUSH;
            flush_q     <= '0;
            timer_q     <= '0;
            go_q        <= 1'b0;
            op_q        <= OP_ADD;
            in1_q       <= '0;
            in2_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= OP_ADD;
            res_err_q   <= 1'b0;
        end else begin
            go_q <= 1'b0;
            if (res_pop) begin
                res_valid_q <= 1'b0;
            end
            case (state_q)
                ST_FLUSH: begin
                    if (flush_q == FLUSH_LAST) begin
                        flush_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        flush_q <= flush_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (issue_ok) begin
                        op_q    <= calc_op_e'(fifo_rdata[2*W +: 2]);
                        in1_q   <= fifo_rdata[W +: W];
                        in2_q   <= fifo_rdata[0 +: W];
                        go_q    <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (calc_done) begin
                        res_data_q  <= calc_res;
                        res_op_q    <= op_q;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (timer_q == TIMER_LAST) begin
                        res_data_q  <= '0;
                        res_op_q    <= op_q;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        flush_q     <= '0;
                        state_q     <= ST_FLUSH;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_FLUSH;
                end
            endcase
        end
    end

    assign go        = go_q;
    assign op        = op_q;
    assign in1       = in1_q;
    assign in2       = in2_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign res_err   = res_err_q;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty || res_valid_q;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench for calc_cmd_sequencer with a behavioural CU+datapath model
// that raises done CU_LATENCY cycles after go with result f(op, a, b).
module tb_calc_cmd_sequencer;
    import calc_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         go;
    logic [1:0]   op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         calc_done;
    logic [W-1:0] calc_res;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic [1:0]   res_op;
    logic         res_err;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    logic                  modelEn   = 1'b1;
    logic                  forceDone = 1'b0;
    logic [CU_LATENCY-1:0] goPipe    = '0;
    logic [W-1:0]          resHold   = '0;

    calc_cmd_sequencer #(
        .W         (W),
        .DEPTH     (4),
        .TIMEOUT   (16),
        .FLUSH_CYC (7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .go        (go),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .calc_done (calc_done),
        .calc_res  (calc_res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .res_err   (res_err),
        .busy      (busy)
    );

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Datapath reference used only to produce calc_res for the CU model.
    function automatic logic [W-1:0] calcModel(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // CU model: done pulses CU_LATENCY cycles after go, result latched at go.
    always @(posedge clk) begin
        goPipe <= {goPipe[CU_LATENCY-2:0], go};
        if (go) begin
            resHold <= calcModel(op, in1, in2);
        end
    end
    assign calc_done = (goPipe[CU_LATENCY-1] && modelEn) || forceDone;
    assign calc_res  = calc_done ? resHold : '0;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (go !== 1'b0) begin errors++; $display("[TB] FAIL reset_go: got %0h want 0", go); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %0h want 0", res_valid); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %0h want 0", cmd_ready); end
        checks++; if ({op, in1, in2} !== 18'h0) begin errors++; $display("[TB] FAIL reset_operands: got %0h want 0", {op, in1, in2}); end
        checks++; if ({res_data, res_op, res_err} !== 11'h0) begin errors++; $display("[TB] FAIL reset_result: got %0h want 0", {res_data, res_op, res_err}); end
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            checks++; if (cmd_ready !== 1'b0 || go !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_cycle%0d: ready=%0h go=%0h busy=%0h want 0/0/1", i, cmd_ready, go, busy); end
            step();
        end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_done_ready: got %0h want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_done_busy: got %0h want 0", busy); end
    endtask

    task automatic test_add();
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h05; cmd_b = 8'h03;
        step();
        cmd_valid = 1'b0;
        checks++; if (go !== 1'b0) begin errors++; $display("[TB] FAIL add_go_early: got %0h want 0", go); end
        step();
        checks++; if (go !== 1'b1) begin errors++; $display("[TB] FAIL add_go: got %0h want 1", go); end
        checks++; if ({op, in1, in2} !== {2'b00, 8'h05, 8'h03}) begin errors++; $display("[TB] FAIL add_operands: got %0h want 00503", {op, in1, in2}); end
        step();
        checks++; if (go !== 1'b0) begin errors++; $display("[TB] FAIL add_go_one_cycle: got %0h want 0", go); end
        repeat (4) step();
        checks++; if (in1 !== 8'h05 || in2 !== 8'h03 || res_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_hold_at_done: in1=%0h in2=%0h rv=%0h want 5/3/0", in1, in2, res_valid); end
        step();
        checks++; if (res_valid !== 1'b1 || res_data !== 8'h08 || res_op !== 2'b00 || res_err !== 1'b0) begin errors++; $display("[TB] FAIL add_result: rv=%0h data=%0h op=%0h err=%0h want 1/08/0/0", res_valid, res_data, res_op, res_err); end
        step();
        checks++; if (res_valid !== 1'b1 || res_data !== 8'h08) begin errors++; $display("[TB] FAIL add_result_held: rv=%0h data=%0h want 1/08", res_valid, res_data); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]   cOp   [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
        logic [W-1:0] cA    [5] = '{8'h09, 8'hF0, 8'hAA, 8'hFF, 8'h01};
        logic [W-1:0] cB    [5] = '{8'h04, 8'h3C, 8'hFF, 8'h01, 8'h01};
        logic [W-1:0] eData [6] = '{8'h08, 8'h05, 8'h30, 8'h55, 8'h00, 8'h02};
        logic [1:0]   eOp   [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
        int nres = 0;
        int ngo = 0;
        int lastGo = 0;
        logic acc;
        res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1'b1; cmd_op = cOp[k]; cmd_a = cA[k]; cmd_b = cB[k];
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready%0d: got %0h want 1", k, cmd_ready); end
            step();
        end
        cmd_op = cOp[4]; cmd_a = cA[4]; cmd_b = cB[4];
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full_ready: got %0h want 0", cmd_ready); end
        checks++; if (go !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_issue_while_full_slot: got %0h want 0", go); end
        res_ready = 1'b1;
        for (int c = 0; c < 80 && nres < 6; c++) begin
            if (go) begin
                if (ngo > 0) begin
                    checks++; if (cycle - lastGo !== 7) begin errors++; $display("[TB] FAIL b2b_go_gap%0d: got %0d want 7", ngo, cycle - lastGo); end
                end
                lastGo = cycle;
                ngo++;
            end
            if (res_valid && res_ready) begin
                checks++; if (res_data !== eData[nres] || res_op !== eOp[nres] || res_err !== 1'b0) begin errors++; $display("[TB] FAIL b2b_result%0d: data=%0h op=%0h err=%0h want %0h/%0h/0", nres, res_data, res_op, res_err, eData[nres], eOp[nres]); end
                nres++;
            end
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) cmd_valid = 1'b0;
        end
        checks++; if (nres !== 6) begin errors++; $display("[TB] FAIL b2b_result_count: got %0d want 6", nres); end
        checks++; if (ngo !== 5) begin errors++; $display("[TB] FAIL b2b_go_count: got %0d want 5", ngo); end
        cmd_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int ngo = 0;
        logic seen = 1'b0;
        logic stable = 1'b1;
        logic [W-1:0] first = '0;
        res_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h10; cmd_b = 8'h20;
        step();
        cmd_op = 2'b01; cmd_a = 8'h50; cmd_b = 8'h10;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (go) ngo++;
            if (res_valid) begin
                if (seen && res_data !== first) stable = 1'b0;
                if (!seen) first = res_data;
                seen = 1'b1;
            end
            step();
        end
        checks++; if (ngo !== 1) begin errors++; $display("[TB] FAIL bp_single_go: got %0d want 1", ngo); end
        checks++; if (res_valid !== 1'b1 || res_data !== 8'h30 || stable !== 1'b1) begin errors++; $display("[TB] FAIL bp_held: rv=%0h data=%0h stable=%0h want 1/30/1", res_valid, res_data, stable); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++; if (go !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_go_after_pop: go=%0h rv=%0h want 1/0", go, res_valid); end
        for (int i = 0; i < 20 && !res_valid; i++) step();
        checks++; if (res_valid !== 1'b1 || res_data !== 8'h40 || res_op !== 2'b01) begin errors++; $display("[TB] FAIL bp_second: rv=%0h data=%0h op=%0h want 1/40/1", res_valid, res_data, res_op); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int ngo = 0;
        modelEn = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_a = 8'h12; cmd_b = 8'h34;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10 && !go; i++) step();
        checks++; if (go !== 1'b1) begin errors++; $display("[TB] FAIL to_go: got %0h want 1", go); end
        repeat (16) step();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_early: got %0h want 0", res_valid); end
        step();
        checks++; if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 8'h00 || res_op !== 2'b11) begin errors++; $display("[TB] FAIL to_error: rv=%0h err=%0h data=%0h op=%0h want 1/1/00/3", res_valid, res_err, res_data, res_op); end
        for (int i = 0; i < 7; i++) begin
            if (go) ngo++;
            forceDone = (i == 0);
            if (i == 1) begin
                checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL to_flush_ready: got %0h want 0", cmd_ready); end
            end
            step();
        end
        forceDone = 1'b0;
        modelEn = 1'b1;
        checks++; if (ngo !== 0) begin errors++; $display("[TB] FAIL to_no_go_in_flush: got %0d want 0", ngo); end
        checks++; if (res_err !== 1'b1 || res_data !== 8'h00) begin errors++; $display("[TB] FAIL to_late_done: err=%0h data=%0h want 1/00", res_err, res_data); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL to_ready_after_flush: got %0h want 1", cmd_ready); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL to_idle: rv=%0h busy=%0h want 0/0", res_valid, busy); end
    endtask

    task automatic test_reset_mid();
        logic [1:0]   cOp [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
        logic [W-1:0] cA  [4] = '{8'h11, 8'h33, 8'h0F, 8'h44};
        logic [W-1:0] cB  [4] = '{8'h22, 8'h11, 8'hF0, 8'h55};
        int ngo = 0;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1'b1; cmd_op = cOp[k]; cmd_a = cA[k]; cmd_b = cB[k];
            step();
        end
        cmd_valid = 1'b0;
        checks++; if ({op, in1, in2} !== {2'b11, 8'h11, 8'h22}) begin errors++; $display("[TB] FAIL rm_in_wait: got %0h want 31122", {op, in1, in2}); end
        step();
        rst_n = 1'b0;
        #1;
        checks++; if (go !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_immediate: go=%0h rv=%0h ready=%0h want 0/0/0", go, res_valid, cmd_ready); end
        checks++; if ({op, in1, in2} !== 18'h0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rm_cleared: ops=%0h busy=%0h want 0/1", {op, in1, in2}, busy); end
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (go) ngo++;
            step();
        end
        checks++; if (ngo !== 0) begin errors++; $display("[TB] FAIL rm_queue_discarded: got %0d go want 0", ngo); end
        checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_idle: busy=%0h rv=%0h want 0/0", busy, res_valid); end
        res_ready = 1'b0;
    endtask

    // Bound on the whole run in case the DUT stalls a wait loop.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
